// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: memory word and the RAM status encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/memory_control.sv
// Single-port RAM arbiter between icache and dcache: dcache has priority, but a
// waiting icache is forced through after STARVE_LIMIT consecutive dcache grants.
module memory_control
   import cpu_types_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
)
(
   input  logic      CLK,
   input  logic      nRST,
   input  logic      iREN,
   input  word_t     iaddr,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      iwait,
   output logic      dwait,
   output word_t     iload,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DSERVE = 2'd1,
      ISERVE = 2'd2
   } state_t;

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   state_t     state_r;
   state_t     next_s;
   logic [2:0] grant_cnt_r;
   logic       dreq_s;
   logic       d_done_s;
   logic       i_done_s;

   assign iload = ramload;
   assign dload = ramload;

   // FSM state and starvation counter
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r     <= IDLE;
         grant_cnt_r <= 3'd0;
      end else begin
         state_r <= next_s;
         if (!iREN) begin
            grant_cnt_r <= 3'd0;
         end else if (i_done_s) begin
            grant_cnt_r <= 3'd0;
         end else if (d_done_s && (grant_cnt_r != 3'd7)) begin
            grant_cnt_r <= grant_cnt_r + 3'd1;
         end else begin
            grant_cnt_r <= grant_cnt_r;
         end
      end
   end

   // Next-state decode and RAM-side / wait outputs
   always_comb begin
      next_s   = state_r;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'd0;
      ramstore = 32'd0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      d_done_s = 1'b0;
      i_done_s = 1'b0;
      dreq_s   = dREN | dWEN;

      case (state_r)
         IDLE: begin
            if (iREN && (grant_cnt_r == LIMIT)) begin
               next_s = ISERVE;
            end else if (dreq_s) begin
               next_s = DSERVE;
            end else if (iREN) begin
               next_s = ISERVE;
            end else begin
               next_s = IDLE;
            end
         end
         DSERVE: begin
            // a withdrawn request releases the RAM without a wait pulse
            if (!dreq_s) begin
               next_s = IDLE;
            end else begin
               ramaddr  = daddr;
               ramstore = dstore;
               ramWEN   = dWEN;
               ramREN   = dREN & ~dWEN;
               if (ramstate == ACCESS) begin
                  dwait    = 1'b0;
                  d_done_s = 1'b1;
                  next_s   = IDLE;
               end else begin
                  next_s = DSERVE;
               end
            end
         end
         ISERVE: begin
            if (!iREN) begin
               next_s = IDLE;
            end else begin
               ramaddr = iaddr;
               ramREN  = 1'b1;
               if (ramstate == ACCESS) begin
                  iwait    = 1'b0;
                  i_done_s = 1'b1;
                  next_s   = IDLE;
               end else begin
                  next_s = ISERVE;
               end
            end
         end
         default: begin
            next_s = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_memory_control.sv
// Directed protocol scenarios followed by randomized traffic checked against a
// transaction-level arbitration model.
module tb_memory_control;
   import cpu_types_pkg::*;

   localparam int LIMIT = 4;

   logic      CLK = 1'b0;
   logic      nRST;
   logic      iREN, dREN, dWEN;
   word_t     iaddr, daddr, dstore, ramload;
   ramstate_t ramstate;
   logic      iwait, dwait, ramREN, ramWEN;
   word_t     iload, dload, ramaddr, ramstore;

   int n_checks = 0;
   int n_fail   = 0;

   // model: who owns the RAM (0 nobody, 1 dcache, 2 icache) and dcache win streak
   int m_owner  = 0;
   int m_streak = 0;

   memory_control #(.STARVE_LIMIT(LIMIT)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic idle_inputs();
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0;
      ramstate = FREE; ramload = 32'd0;
   endtask

   // check this cycle's outputs against the model, then advance the model
   task automatic model_check();
      logic  e_ren, e_wen, e_iw, e_dw, acc, dreq;
      word_t e_addr, e_store;
      int    nxt, nstk;
      acc = (ramstate == ACCESS);
      dreq = dREN | dWEN;
      e_ren = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
      e_addr = 32'd0; e_store = 32'd0;
      nxt = m_owner; nstk = m_streak;
      if (m_owner == 0) begin
         if (iREN && m_streak >= LIMIT) nxt = 2;
         else if (dreq) nxt = 1;
         else if (iREN) nxt = 2;
         else nxt = 0;
      end else if (m_owner == 1) begin
         if (!dreq) nxt = 0;
         else begin
            e_addr = daddr; e_store = dstore;
            e_wen = dWEN; e_ren = dREN && !dWEN;
            if (acc) begin e_dw = 1'b0; nxt = 0; nstk = m_streak + 1; end
         end
      end else begin
         if (!iREN) nxt = 0;
         else begin
            e_addr = iaddr; e_ren = 1'b1;
            if (acc) begin e_iw = 1'b0; nxt = 0; nstk = 0; end
         end
      end
      if (!iREN) nstk = 0;
      chk("rnd_ramREN", {31'd0, ramREN}, {31'd0, e_ren});
      chk("rnd_ramWEN", {31'd0, ramWEN}, {31'd0, e_wen});
      chk("rnd_ramaddr", ramaddr, e_addr);
      chk("rnd_ramstore", ramstore, e_store);
      chk("rnd_iwait", {31'd0, iwait}, {31'd0, e_iw});
      chk("rnd_dwait", {31'd0, dwait}, {31'd0, e_dw});
      chk("rnd_iload", iload, ramload);
      chk("rnd_dload", dload, ramload);
      m_owner = nxt;
      m_streak = nstk;
   endtask

   initial begin
      int dcnt;
      logic got;
      int r;

      idle_inputs();
      nRST = 1'b0;
      #1;
      chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
      chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
      chk("rst_ramaddr", ramaddr, 32'd0);
      chk("rst_ramstore", ramstore, 32'd0);
      chk("rst_iwait", {31'd0, iwait}, 32'd1);
      chk("rst_dwait", {31'd0, dwait}, 32'd1);
      tick(); nRST = 1'b1;

      // dcache read, two BUSY then ACCESS
      tick(); dREN = 1'b1; daddr = 32'h40; ramstate = BUSY; #1;
      chk("rd_idle_ramREN", {31'd0, ramREN}, 32'd0);
      chk("rd_idle_ramaddr", ramaddr, 32'd0);
      for (int k = 0; k < 2; k++) begin
         tick(); #1;
         chk("rd_busy_ramREN", {31'd0, ramREN}, 32'd1);
         chk("rd_busy_ramaddr", ramaddr, 32'h40);
         chk("rd_busy_dwait", {31'd0, dwait}, 32'd1);
      end
      tick(); ramstate = ACCESS; ramload = 32'h1234_5678; #1;
      chk("rd_acc_ramREN", {31'd0, ramREN}, 32'd1);
      chk("rd_acc_ramaddr", ramaddr, 32'h40);
      chk("rd_acc_dwait", {31'd0, dwait}, 32'd0);
      chk("rd_acc_dload", dload, 32'h1234_5678);
      tick(); dREN = 1'b0; ramstate = FREE; #1;
      chk("rd_after_ramREN", {31'd0, ramREN}, 32'd0);
      chk("rd_after_dwait", {31'd0, dwait}, 32'd1);

      // simultaneous icache read and dcache write: dcache first
      tick(); iREN = 1'b1; iaddr = 32'h100; dWEN = 1'b1; daddr = 32'h80;
      dstore = 32'hDEAD_BEEF; #1;
      chk("wr_idle_ramWEN", {31'd0, ramWEN}, 32'd0);
      tick(); ramstate = ACCESS; #1;
      chk("wr_ramWEN", {31'd0, ramWEN}, 32'd1);
      chk("wr_ramREN", {31'd0, ramREN}, 32'd0);
      chk("wr_ramstore", ramstore, 32'hDEAD_BEEF);
      chk("wr_ramaddr", ramaddr, 32'h80);
      chk("wr_dwait", {31'd0, dwait}, 32'd0);
      chk("wr_iwait", {31'd0, iwait}, 32'd1);
      tick(); dWEN = 1'b0; #1;
      chk("wr_gap_ramREN", {31'd0, ramREN}, 32'd0);
      chk("wr_gap_iwait", {31'd0, iwait}, 32'd1);
      tick(); ramload = 32'hCAFE_0001; #1;
      chk("if_ramREN", {31'd0, ramREN}, 32'd1);
      chk("if_ramaddr", ramaddr, 32'h100);
      chk("if_ramstore", ramstore, 32'd0);
      chk("if_iwait", {31'd0, iwait}, 32'd0);
      chk("if_iload", iload, 32'hCAFE_0001);
      tick(); iREN = 1'b0; #1;
      chk("if_after_ramREN", {31'd0, ramREN}, 32'd0);

      // read and write together: write wins
      tick(); dREN = 1'b1; dWEN = 1'b1; ramstate = ACCESS;
      tick(); #1;
      chk("rw_ramWEN", {31'd0, ramWEN}, 32'd1);
      chk("rw_ramREN", {31'd0, ramREN}, 32'd0);
      chk("rw_dwait", {31'd0, dwait}, 32'd0);
      tick(); idle_inputs();

      // starvation: icache held while dcache re-requests back to back
      tick(); iREN = 1'b1; iaddr = 32'h180; dREN = 1'b1; daddr = 32'h90; ramstate = ACCESS;
      dcnt = 0; got = 1'b0;
      for (int k = 0; k < 30 && !got; k++) begin
         tick(); #1;
         if (dwait === 1'b0) dcnt++;
         if (iwait === 1'b0) got = 1'b1;
      end
      chk("starve_igrant", {31'd0, got}, 32'd1);
      chk("starve_dcount", dcnt, LIMIT);
      tick(); idle_inputs();

      // reset during a BUSY dcache transfer, icache pending
      tick(); dREN = 1'b1; daddr = 32'h44; iREN = 1'b1; iaddr = 32'h200; ramstate = BUSY;
      tick(); #1;
      chk("rstmid_pre_ramREN", {31'd0, ramREN}, 32'd1);
      #2; nRST = 1'b0; #1;
      chk("rstmid_ramREN", {31'd0, ramREN}, 32'd0);
      chk("rstmid_ramaddr", ramaddr, 32'd0);
      chk("rstmid_dwait", {31'd0, dwait}, 32'd1);
      tick(); dREN = 1'b0; nRST = 1'b1; #1;
      chk("rstmid_idle_ramREN", {31'd0, ramREN}, 32'd0);
      tick(); ramstate = ACCESS; #1;
      chk("rstmid_i_ramREN", {31'd0, ramREN}, 32'd1);
      chk("rstmid_i_ramaddr", ramaddr, 32'h200);
      chk("rstmid_i_iwait", {31'd0, iwait}, 32'd0);
      tick(); idle_inputs();

      // icache withdraws while RAM is BUSY
      tick(); iREN = 1'b1; iaddr = 32'h300; ramstate = BUSY;
      tick(); #1;
      chk("wd_busy_ramREN", {31'd0, ramREN}, 32'd1);
      chk("wd_busy_iwait", {31'd0, iwait}, 32'd1);
      tick(); iREN = 1'b0; #1;
      chk("wd_drop_ramREN", {31'd0, ramREN}, 32'd0);
      chk("wd_drop_iwait", {31'd0, iwait}, 32'd1);
      tick(); iREN = 1'b1; #1;
      chk("wd_idle_ramREN", {31'd0, ramREN}, 32'd0);
      tick(); #1;
      chk("wd_regrant_ramREN", {31'd0, ramREN}, 32'd1);
      tick(); idle_inputs();

      // randomized traffic against the model
      tick(); nRST = 1'b0;
      tick(); nRST = 1'b1;
      m_owner = 0; m_streak = 0;
      for (int c = 0; c < 2000; c++) begin
         tick();
         if ($urandom_range(0, 249) == 0) begin
            nRST = 1'b0; #1;
            chk("rnd_rst_ramREN", {31'd0, ramREN}, 32'd0);
            chk("rnd_rst_dwait", {31'd0, dwait}, 32'd1);
            tick(); nRST = 1'b1;
            m_owner = 0; m_streak = 0;
         end
         iREN   = ($urandom_range(0, 9) < 8);
         dREN   = ($urandom_range(0, 9) < 5);
         dWEN   = ($urandom_range(0, 9) < 2);
         iaddr  = $urandom;
         daddr  = $urandom;
         dstore = $urandom;
         ramload = $urandom;
         r = $urandom_range(0, 7);
         if (r < 4) ramstate = ACCESS;
         else if (r == 5) ramstate = FREE;
         else if (r == 6) ramstate = ERROR;
         else ramstate = BUSY;
         #1;
         model_check();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_control.md
MEMORY_CONTROL -- requirements
Module: memory_control

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive dcache grants allowed while an icache request waits.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 iREN  in  1  icache read request.
REQ-005 iaddr  in  32  icache word address.
REQ-006 dREN  in  1  dcache read request.
REQ-007 dWEN  in  1  dcache write request.
REQ-008 daddr  in  32  dcache word address.
REQ-009 dstore  in  32  dcache write data.
REQ-010 iwait  out  1  1 = icache request not yet complete.
REQ-011 dwait  out  1  1 = dcache request not yet complete.
REQ-012 iload  out  32  read data to icache.
REQ-013 dload  out  32  read data to dcache.
REQ-014 ramREN  out  1  RAM read strobe.
REQ-015 ramWEN  out  1  RAM write strobe.
REQ-016 ramaddr  out  32  RAM address.
REQ-017 ramstore  out  32  RAM write data.
REQ-018 ramload  in  32  RAM read data.
REQ-019 ramstate  in  2  RAM status: FREE, BUSY, ACCESS, ERROR.

Function
REQ-020 The block SHALL be the responder end of the cache-to-memory protocol, servicing one request at a time.
REQ-021 FSM states: IDLE, DSERVE, ISERVE.
REQ-022 IDLE: dREN|dWEN -> DSERVE, else iREN -> ISERVE, else stay; exception in REQ-027.
REQ-023 DSERVE: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both asserted).
REQ-024 ISERVE: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-025 Completion: in DSERVE/ISERVE, the cycle ramstate==ACCESS the matching wait SHALL be 0 for exactly that cycle; next state IDLE.
REQ-026 BUSY, FREE and ERROR in a serve state SHALL hold wait=1 and keep strobes asserted (retry).
REQ-027 Starvation: 3-bit dcache-grant counter increments on each DSERVE completion while iREN=1, clears on ISERVE completion or when iREN=0; when count==STARVE_LIMIT and iREN=1, IDLE SHALL go to ISERVE.
REQ-028 Withdrawal: if the served requester drops its request (dREN=dWEN=0 or iREN=0) in a serve state, strobes SHALL deassert that cycle, no wait pulse, next state IDLE.
REQ-029 iload=ramload and dload=ramload, combinational pass-through.
REQ-030 Outside a completion cycle, iwait=1 and dwait=1; in IDLE all RAM strobes are 0 and ramaddr=0.
REQ-031 Minimum latency: request at cycle N, grant state at N+1, earliest wait=0 at N+1 if RAM returns ACCESS.

Reset
REQ-032 nRST low SHALL force IDLE, counter 0, ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, asynchronously, including mid-transfer.
REQ-033 After release, the first grant SHALL occur no earlier than the first rising edge with nRST high.

Structure
REQ-034 word_t (32 bits) and ramstate_t (FREE, BUSY, ACCESS, ERROR) SHALL come from cpu_types_pkg; FSM enum local to the module.
REQ-035 Single module, no sub-modules; FSM and counter in one always_ff, outputs in always_comb.

Verification
REQ-036 dREN=1, daddr=0x40, RAM ACCESS after 2 BUSY -> ramREN=1, ramaddr=0x40 for 3 cycles, dwait=0 on third, dload=ramload.
REQ-037 iREN=1 and dWEN=1 same cycle, dstore=0xDEADBEEF -> DSERVE first, ramWEN=1, ramstore=0xDEADBEEF; ISERVE follows.
REQ-038 iREN held, dREN reissued back-to-back, STARVE_LIMIT=4 -> 4 dcache completions, then iwait=0 before the 5th dcache grant.
REQ-039 dREN=dWEN=1 same cycle -> ramWEN=1, ramREN=0.
REQ-040 nRST low during DSERVE with BUSY -> strobes 0, dwait=1 immediately; after release, pending iREN served from IDLE.
REQ-041 iREN dropped while ramstate=BUSY -> ramREN=0 that cycle, no iwait pulse, FSM IDLE.
